lfsr_seq_checker: RTL and testbench

Downstream companion to the 26-bit LFSR: consumes one 26-bit state word per valid cycle, predicts the next word from the previous one, and reports lock status and error counts. It self-synchronises from the received stream, so no seed has to be shared with the generator. It sits directly after the LFSR output `q` in PRBS test paths.

---
 rtl/lfsr_seq_checker.sv | 72 +++++++
 tb/tb_lfsr_seq_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising checker for a 26-bit LFSR stream with lock tracking and saturating error count.
`timescale 1ns/1ps
module lfsr_seq_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [1:26]      din,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic             zero_pulse,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int HW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(LOSS_CNT + 1);
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
   state_t state, state_nx;
   logic [1:26] ref_w, step;
   logic have_ref, cmp, match, is_zero, err;
   logic [HW-1:0] hit_cnt;
   logic [MW-1:0] miss_cnt;
   logic [CNT_W-1:0] cnt_base, cnt_nx;
   assign step = {ref_w[26] ^ ref_w[6] ^ ref_w[2] ^ ref_w[1], ref_w[1:25]};
   assign is_zero = din == '0;
   assign cmp = valid && have_ref;
   assign match = (din == step) && !is_zero;
   assign err = cmp && !match && state == LOCKED;
   // clear takes effect before the increment, so clr plus an error leaves 1
   assign cnt_base = clr ? '0 : err_cnt;
   assign cnt_nx = (err && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= HUNT;
      else state <= state_nx;
   always_comb begin
      state_nx = (cmp && state == HUNT && match && hit_cnt == HW'(LOCK_CNT - 1)) ? LOCKED :
                 (err && miss_cnt == MW'(LOSS_CNT - 1)) ? HUNT : state;
   end
   always_comb begin
      locked = state == LOCKED;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_w      <= '0;
         have_ref   <= 1'b0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         err_pulse  <= 1'b0;
         zero_pulse <= 1'b0;
         err_cnt    <= '0;
      end else begin
         if (valid) begin
            ref_w    <= din;
            have_ref <= 1'b1;
         end
         if (cmp && state == HUNT) begin
            hit_cnt <= match ? hit_cnt + 1'b1 : '0;
            if (state_nx == LOCKED) miss_cnt <= '0;
         end
         if (cmp && state == LOCKED) begin
            miss_cnt <= match ? '0 : miss_cnt + 1'b1;
            if (state_nx == HUNT) hit_cnt <= '0;
         end
         err_pulse  <= err;
         zero_pulse <= valid && is_zero;
         err_cnt    <= cnt_nx;
      end
   end
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed checks of lock/loss, error counting, saturation, clr and async reset.
`timescale 1ns/1ps
module tb_lfsr_seq_checker;
   logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, clr = 1'b0, v4 = 1'b0, clr4 = 1'b0;
   logic [1:26] din = '0, d4 = '0, w, w4, m;
   logic locked, err_pulse, zero_pulse, l4, ep4, zp4;
   logic [15:0] err_cnt;
   logic [3:0] ec4;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   lfsr_seq_checker dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .din(din), .clr(clr),
      .locked(locked), .err_pulse(err_pulse), .zero_pulse(zero_pulse), .err_cnt(err_cnt)
   );
   lfsr_seq_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid(v4), .din(d4), .clr(clr4),
      .locked(l4), .err_pulse(ep4), .zero_pulse(zp4), .err_cnt(ec4)
   );

   function automatic logic [1:26] step_f(input logic [1:26] x);
      return {x[26] ^ x[6] ^ x[2] ^ x[1], x[1:25]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [1:26] x);
      @(negedge clk);
      din = x;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic send4(input logic [1:26] x, input logic c);
      @(negedge clk);
      d4 = x;
      v4 = 1'b1;
      clr4 = c;
      @(posedge clk);
      #1 v4 = 1'b0;
      clr4 = 1'b0;
   endtask

   initial begin
      m = '0;
      m[13] = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_locked", locked, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_zero_pulse", zero_pulse, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      // lock acquisition: capture + 4 matches
      w = 26'b10010110101101000111111000;
      send(w);
      chk("capture_no_lock", locked, 0);
      w = 26'b01001011010110100011111100;
      send(w);
      for (int i = 2; i <= 9; i++) begin
         w = step_f(w);
         send(w);
         if (i == 3) chk("pre_lock_4th", locked, 0);
         if (i == 4) chk("lock_5th", locked, 1);
      end
      chk("clean_err_cnt", err_cnt, 0);
      chk("clean_locked", locked, 1);
      // single corrupted word gives two mismatches
      w = step_f(w);
      send(w ^ m);
      chk("corrupt_pulse", err_pulse, 1);
      chk("corrupt_cnt1", err_cnt, 1);
      w = step_f(w);
      send(w);
      chk("after_corrupt_pulse", err_pulse, 1);
      chk("after_corrupt_cnt2", err_cnt, 2);
      w = step_f(w);
      send(w);
      chk("recover_pulse", err_pulse, 0);
      chk("recover_cnt", err_cnt, 2);
      chk("corrupt_keep_lock", locked, 1);
      // three junk words drop lock
      send(26'h1234567);
      chk("junk1_cnt", err_cnt, 3);
      chk("junk1_locked", locked, 1);
      send(26'h0ABCDEF);
      chk("junk2_cnt", err_cnt, 4);
      chk("junk2_locked", locked, 1);
      send(26'h3F0F0F0);
      chk("junk3_cnt", err_cnt, 5);
      chk("junk3_pulse", err_pulse, 1);
      chk("junk3_unlocked", locked, 0);
      for (int i = 1; i <= 5; i++) begin
         w = step_f(w);
         send(w);
         if (i == 4) chk("relock_4th", locked, 0);
         if (i == 5) chk("relock_5th", locked, 1);
      end
      chk("hunt_no_count", err_cnt, 5);
      // all-zero word
      send('0);
      chk("zero_zp", zero_pulse, 1);
      chk("zero_ep", err_pulse, 1);
      chk("zero_cnt", err_cnt, 6);
      chk("zero_locked", locked, 1);
      w = step_f(w);
      send(w);
      chk("post_zero_cnt", err_cnt, 7);
      chk("post_zero_zp", zero_pulse, 0);
      w = step_f(w);
      send(w);
      chk("post_zero_match", err_pulse, 0);
      chk("post_zero_locked", locked, 1);
      // idle gap keeps everything
      repeat (3) @(posedge clk);
      #1;
      chk("gap_ep", err_pulse, 0);
      chk("gap_locked", locked, 1);
      w = step_f(w);
      send(w);
      chk("gap_resume_ep", err_pulse, 0);
      chk("gap_resume_cnt", err_cnt, 7);
      // 4-bit counter saturation and clr
      w4 = 26'b10010110101101000111111000;
      send4(w4, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         w4 = step_f(w4);
         send4(w4, 1'b0);
      end
      chk("w4_lock", l4, 1);
      for (int k = 0; k < 10; k++) begin
         w4 = step_f(w4);
         send4(w4 ^ m, 1'b0);
         w4 = step_f(w4);
         send4(w4, 1'b0);
         w4 = step_f(w4);
         send4(w4, 1'b0);
         if (k == 6) chk("w4_cnt14", ec4, 14);
         if (k == 7) chk("w4_cnt15", ec4, 15);
      end
      chk("w4_saturate", ec4, 15);
      chk("w4_still_locked", l4, 1);
      w4 = step_f(w4);
      send4(w4 ^ m, 1'b1);
      chk("w4_clr_err", ec4, 1);
      chk("w4_clr_pulse", ep4, 1);
      w4 = step_f(w4);
      send4(w4, 1'b0);
      chk("w4_after_clr", ec4, 2);
      // asynchronous reset mid-stream
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_err_cnt", err_cnt, 0);
      chk("arst_l4", l4, 0);
      chk("arst_ec4", ec4, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         w = step_f(w);
         send(w);
         if (i == 1) chk("arst_capture_ep", err_pulse, 0);
         if (i == 4) chk("arst_relock_4th", locked, 0);
         if (i == 5) chk("arst_relock_5th", locked, 1);
      end
      chk("arst_final_cnt", err_cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
